glb_feeder: RTL

GLB_FEEDER -- requirements
Module: glb_feeder

---
 rtl/glb_feeder_pkg.sv | 25 ++
 rtl/glb_feeder_if.sv | 34 +++
 rtl/feeder_tag_counter.sv | 39 +++
 rtl/glb_feeder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/glb_feeder_pkg.sv
// Shared definitions for the GLB feeder.
//   state_t          : FSM state encoding
//   DATA_LSB         : bit offset of the data word inside a GIN packet
//   col_lsb/row_lsb  : bit offsets of the col and row tags (row tag in MSBs)
package glb_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DATA_LSB = 0;

   function automatic int col_lsb(input int bitwidth);
      return bitwidth;
   endfunction

   function automatic int row_lsb(input int bitwidth, input int tag_length);
      return bitwidth + tag_length;
   endfunction

endpackage

// File: rtl/glb_feeder_if.sv
// Bundle of the feeder's control, GLB read port and GIN packet port.
//   master : the feeder side (drives status, GLB controls, GIN packet)
//   slave  : the environment side (drives start/config, GLB data, GIN ready)
interface glb_feeder_if #(
   parameter int BITWIDTH        = 16,
   parameter int TAG_LENGTH      = 4,
   parameter int GLB_ADDR_LENGTH = 3,
   parameter int PACKET_LENGTH   = 2*TAG_LENGTH + BITWIDTH
);
   logic                       start;
   logic [GLB_ADDR_LENGTH-1:0] cfg_base_addr;
   logic [TAG_LENGTH-1:0]      cfg_num_rows;
   logic [TAG_LENGTH-1:0]      cfg_num_cols;
   logic                       busy;
   logic                       done;
   logic [GLB_ADDR_LENGTH-1:0] glb_addr;
   logic [BITWIDTH-1:0]        glb_rdata;
   logic                       glb_cs;
   logic                       glb_we;
   logic                       glb_oe;
   logic                       gin_enable;
   logic                       gin_ready;
   logic [PACKET_LENGTH-1:0]   data_packet;

   modport master (
      input  start, cfg_base_addr, cfg_num_rows, cfg_num_cols, glb_rdata, gin_ready,
      output busy, done, glb_addr, glb_cs, glb_we, glb_oe, gin_enable, data_packet
   );

   modport slave (
      output start, cfg_base_addr, cfg_num_rows, cfg_num_cols, glb_rdata, gin_ready,
      input  busy, done, glb_addr, glb_cs, glb_we, glb_oe, gin_enable, data_packet
   );
endinterface

// File: rtl/feeder_tag_counter.sv
// Row/col tag counter. Col advances on inc and wraps at num_cols-1, carrying
// into row. last flags the final element of a num_rows x num_cols walk.
//   clk, rst (sync, active high), clear (return to 0,0), inc (advance)
//   num_rows, num_cols : held transfer geometry
//   row, col, last     : current tags and final-element flag
module feeder_tag_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] num_rows,
   input  logic [W-1:0] num_cols,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         last
);
   localparam logic [W-1:0] ONE = W'(1);

   logic col_wrap;

   assign col_wrap = (col == num_cols - ONE);
   assign last     = (row == num_rows - ONE) && col_wrap;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (col_wrap) begin
            col <= '0;
            row <= row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end
endmodule

// File: rtl/glb_feeder.sv
// GLB feeder: walks num_rows x num_cols words of the GLB starting at a base
// address and forwards each as a {row_tag, col_tag, data} packet to GIN.
//   clk, rstb (sync, active high)
//   bus : glb_feeder_if master (start/config, busy/done, GLB read, GIN send)
//
//   state   | meaning
//   IDLE    | waiting for start
//   READ    | GLB read of current address
//   CAPTURE | GLB data returns, latched with tags into the packet
//   SEND    | packet offered to GIN until accepted
//   DONE    | one-cycle completion pulse
module glb_feeder
   import glb_feeder_pkg::*;
#(
   parameter int BITWIDTH        = 16,
   parameter int TAG_LENGTH      = 4,
   parameter int GLB_ADDR_LENGTH = 3,
   parameter int PACKET_LENGTH   = 2*TAG_LENGTH + BITWIDTH
) (
   input logic          clk,
   input logic          rstb,
   glb_feeder_if.master bus
);
   localparam int COL_LSB = col_lsb(BITWIDTH);
   localparam int ROW_LSB = row_lsb(BITWIDTH, TAG_LENGTH);

   state_t                     state, state_nx;
   logic [TAG_LENGTH-1:0]      rows_q, cols_q, row, col;
   logic [GLB_ADDR_LENGTH-1:0] addr_q;
   logic [PACKET_LENGTH-1:0]   pkt_q, pkt_nx;
   logic                       start_ok, handshake, last, tag_inc;

   feeder_tag_counter #(.W(TAG_LENGTH)) u_tag_counter (
      .clk      (clk),
      .rst      (rstb),
      .clear    (start_ok),
      .inc      (tag_inc),
      .num_rows (rows_q),
      .num_cols (cols_q),
      .row      (row),
      .col      (col),
      .last     (last)
   );

   assign tag_inc = handshake && !last;

   always_comb begin
      pkt_nx = '0;
      pkt_nx[ROW_LSB +: TAG_LENGTH] = row;
      pkt_nx[COL_LSB +: TAG_LENGTH] = col;
      pkt_nx[DATA_LSB +: BITWIDTH]  = bus.glb_rdata;
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state  <= ST_IDLE;
         rows_q <= '0;
         cols_q <= '0;
         addr_q <= '0;
         pkt_q  <= '0;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            rows_q <= bus.cfg_num_rows;
            cols_q <= bus.cfg_num_cols;
            addr_q <= bus.cfg_base_addr;
         end else if (tag_inc) begin
            addr_q <= addr_q + 1'b1;
         end
         if (state == ST_CAPTURE) begin
            pkt_q <= pkt_nx;
         end
      end
   end

   always_comb begin
      state_nx        = state;
      start_ok        = 1'b0;
      handshake       = 1'b0;
      bus.busy        = (state != ST_IDLE);
      bus.done        = 1'b0;
      bus.glb_cs      = 1'b0;
      bus.glb_oe      = 1'b0;
      bus.glb_we      = 1'b0;
      bus.gin_enable  = 1'b0;
      bus.glb_addr    = addr_q;
      bus.data_packet = pkt_q;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               start_ok = 1'b1;
               // an empty geometry completes immediately without touching GLB
               if (bus.cfg_num_rows == '0 || bus.cfg_num_cols == '0) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_READ;
               end
            end
         end
         ST_READ: begin
            bus.glb_cs = 1'b1;
            bus.glb_oe = 1'b1;
            state_nx   = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_nx = ST_SEND;
         end
         ST_SEND: begin
            bus.gin_enable = 1'b1;
            if (bus.gin_ready) begin
               handshake = 1'b1;
               state_nx  = last ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            bus.done = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end
endmodule
